// File: rtl/arcade_input_mapper.sv
// Registered control-input mapper between hps_io and the game core: per-mode
// joystick decode, spinner position accumulator, coin stretcher and DIP capture.
module arcade_input_mapper #(
  parameter int unsigned PLAYERS      = 2,
  parameter int unsigned SPIN_BITS    = 4,
  parameter int unsigned SPIN_DIV     = 25000,
  parameter int unsigned DEADZONE     = 8,
  parameter int unsigned COIN_STRETCH = 250000,
  parameter int unsigned DSW_BYTES    = 8,
  parameter logic [63:0] DSW_DEFAULT  = 64'h0
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic [16*PLAYERS-1:0]   joy,
  input  logic [16*PLAYERS-1:0]   joya,
  input  logic                    adc_sel,
  input  logic                    ioctl_wr,
  input  logic [7:0]              ioctl_index,
  input  logic [24:0]             ioctl_addr,
  input  logic [7:0]              ioctl_dout,
  output logic [7:0]              jb,
  output logic [7:0]              buttons,
  output logic [7:0]              extra_buttons,
  output logic [SPIN_BITS-1:0]    spinner,
  output logic                    coin,
  output logic [8*DSW_BYTES-1:0]  dsw
);

  localparam int unsigned PW    = SPIN_BITS + 7;
  localparam int unsigned DW    = (SPIN_DIV > 1) ? $clog2(SPIN_DIV) : 1;
  localparam int unsigned CW    = $clog2(COIN_STRETCH + 1);
  localparam int unsigned DSW_W = 8 * DSW_BYTES;

  logic [15:0]   j;
  logic [15:0]   a;
  logic [3:0]    tread;
  logic [7:0]    s;
  logic [7:0]    jb_d, buttons_d, extra_d;
  logic [8:0]    mag;
  logic          tick;
  logic [DW-1:0] pre;
  logic [PW-1:0] pos, pos_d;
  logic          hist, hist_vld, rise_q;
  logic [CW-1:0] coin_cnt, coin_cnt_d;
  logic          dsw_hit;
  logic          unused_bits;

  // Digital words from all players are OR-combined; analog is player 0 only.
  always_comb begin
    j = '0;
    for (int p = 0; p < int'(PLAYERS); p++) j = j | joy[16*p +: 16];
  end
  assign a = joya[15:0];
  assign unused_bits = ^{j[15:8], joya};

  // Tank tread decode: {U,D,L,R} -> {WF,WB,XF,XB}
  always_comb begin
    tread = 4'b0000;
    case (j[3:0])
      4'b1000: tread = 4'b1010;
      4'b1010: tread = 4'b0010;
      4'b1001: tread = 4'b1000;
      4'b0001: tread = 4'b1001;
      4'b0101: tread = 4'b0100;
      4'b0100: tread = 4'b0101;
      4'b0110: tread = 4'b0001;
      4'b0010: tread = 4'b0110;
      default: tread = 4'b0000;
    endcase
  end

  // ADC value is 192 plus half the signed stick sample, keeping it in 128..255.
  always_comb begin
    jb_d      = '0;
    buttons_d = '0;
    extra_d   = '0;
    s         = adc_sel ? a[7:0] : a[15:8];
    case (mode)
      2'd0: begin
        jb_d      = {coin, j[5], j[6], j[4], tread};
        buttons_d = {2'b00, j[5], j[6] | j[4], tread};
      end
      2'd1: begin
        jb_d      = {~coin, j[5], j[6], j[4], j[2], j[3], j[0], j[1]};
        buttons_d = 8'd192 + {s[7], s[7:1]};
        extra_d   = {j[4], j[5], 6'b0};
      end
      2'd2: begin
        jb_d      = {coin, j[5], j[6], j[4], 4'b0};
        buttons_d = {2'b00, j[5], j[6] | j[4], 4'b0};
      end
      default: jb_d = {coin, j[6:0]};
    endcase
  end

  // Spinner accumulator; analog beyond the deadzone overrides the digital stick.
  assign tick = (pre == DW'(SPIN_DIV - 1));
  assign mag  = a[7] ? (9'd256 - {1'b0, a[7:0]}) : {1'b0, a[7:0]};

  always_comb begin
    pos_d = pos;
    if (tick && mode == 2'd2) begin
      if (mag > 9'(DEADZONE))       pos_d = pos + {{(PW-8){a[7]}}, a[7:0]};
      else if (j[0] && !j[1])       pos_d = pos + PW'(64);
      else if (j[1] && !j[0])       pos_d = pos - PW'(64);
    end
  end

  // Coin stretch counter: only an idle counter accepts a new edge.
  always_comb begin
    coin_cnt_d = coin_cnt;
    if (coin_cnt != '0) coin_cnt_d = coin_cnt - CW'(1);
    else if (rise_q)    coin_cnt_d = CW'(COIN_STRETCH);
  end

  assign dsw_hit = ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr[24:3] == '0)
                   && ({1'b0, ioctl_addr[2:0]} < 4'(DSW_BYTES));

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      jb            <= '0;
      buttons       <= '0;
      extra_buttons <= '0;
      pre           <= '0;
      pos           <= '0;
      hist          <= 1'b0;
      hist_vld      <= 1'b0;
      rise_q        <= 1'b0;
      coin_cnt      <= '0;
      coin          <= 1'b0;
      dsw           <= DSW_DEFAULT[DSW_W-1:0];
    end else begin
      jb            <= jb_d;
      buttons       <= buttons_d;
      extra_buttons <= extra_d;
      pre           <= tick ? '0 : pre + DW'(1);
      pos           <= pos_d;
      hist          <= j[7];
      hist_vld      <= 1'b1;
      // The first sample after reset only primes the history.
      rise_q        <= j[7] & ~hist & hist_vld;
      coin_cnt      <= coin_cnt_d;
      coin          <= (coin_cnt_d != '0);
      for (int n = 0; n < int'(DSW_BYTES); n++)
        if (dsw_hit && ioctl_addr[2:0] == 3'(n)) dsw[8*n +: 8] <= ioctl_dout;
    end
  end

  assign spinner = pos[PW-1 -: SPIN_BITS];

endmodule
